vga_sprite_renderer: RTL and testbench



---
 rtl/vga_pkg.sv | 36 +++
 rtl/trex_sprite_rom.sv | 52 +++++
 rtl/vga_sprite_renderer.sv | 146 ++++++++++++++
 tb/tb_vga_sprite_renderer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing, sprite and colour definitions for the VGA sprite pixel pipeline.
package vga_pkg;

   localparam logic [9:0]  H_TOTAL     = 10'd800;
   localparam logic [9:0]  V_TOTAL     = 10'd521;
   localparam logic [9:0]  H_ACT_START = 10'd144;
   localparam logic [9:0]  H_ACT_END   = 10'd784;
   localparam logic [9:0]  V_ACT_START = 10'd31;
   localparam logic [9:0]  V_ACT_END   = 10'd511;
   localparam logic [9:0]  CNT_MAX     = 10'd1023;

   localparam logic [10:0] SPRITE_W    = 11'd32;
   localparam logic [10:0] SPRITE_H    = 11'd32;
   localparam logic [10:0] GROUND_Y    = 11'd400;
   localparam logic [10:0] GROUND_H    = 11'd2;

   typedef logic [11:0] rgb12_t;

   localparam rgb12_t BG_COLOR  = 12'hFFF;
   localparam rgb12_t FG_COLOR  = 12'h555;
   localparam rgb12_t GND_COLOR = 12'h333;

   // Everything the output stage needs, captured alongside the ROM read.
   typedef struct packed {
      logic       hit;
      logic [4:0] col;
      logic       gnd;
      logic       active;
      logic       hs;
      logic       vs;
   } stage1_t;

   localparam stage1_t S1_RESET = '{hit: 1'b0, col: 5'd0, gnd: 1'b0,
                                    active: 1'b0, hs: 1'b1, vs: 1'b1};

endpackage

// File: rtl/trex_sprite_rom.sv
// 32x32 1bpp T-rex bitmap, synchronous read; bit 31 of each row is the leftmost pixel.
module trex_sprite_rom
   import vga_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  addr,
   output logic [31:0] data
);

   logic [31:0] data_d;
   logic [31:0] data_q;

   always_comb begin
      data_d = 32'h0000_0000;
      case (addr)
         5'd0:    data_d = 32'h8000_0001;
         5'd1:    data_d = 32'h0000_3FC0;
         5'd2:    data_d = 32'h0000_7FE0;
         5'd3:    data_d = 32'h0000_6FE0;
         5'd4:    data_d = 32'h0000_7FE0;
         5'd5:    data_d = 32'h0000_7FE0;
         5'd6:    data_d = 32'h0000_7E00;
         5'd7:    data_d = 32'h0000_7FC0;
         5'd8:    data_d = 32'h0000_FC00;
         5'd9:    data_d = 32'h8001_FC00;
         5'd10:   data_d = 32'h8007_FF00;
         5'd11:   data_d = 32'hC01F_F900;
         5'd12:   data_d = 32'hE03F_F800;
         5'd13:   data_d = 32'hF0FF_F800;
         5'd14:   data_d = 32'hFFFF_F000;
         5'd15:   data_d = 32'h7FFF_F000;
         5'd16:   data_d = 32'h3FFF_E000;
         5'd17:   data_d = 32'h1FFF_C000;
         5'd18:   data_d = 32'h0FFF_8000;
         5'd19:   data_d = 32'h07FF_0000;
         5'd20:   data_d = 32'h03EE_0000;
         5'd21:   data_d = 32'h01C6_0000;
         5'd22:   data_d = 32'h0184_0000;
         5'd23:   data_d = 32'h0106_0000;
         default: data_d = 32'h0000_0000;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) data_q <= 32'h0000_0000;
      else        data_q <= data_d;
   end

   assign data = data_q;

endmodule

// File: rtl/vga_sprite_renderer.sv
// Pixel stage after the VGA timing generator: sprite over ground stripe and background, 2-cycle latency.
// Define SPRITE_SCALE2X_EN to draw every ROM bit as a 2x2 pixel block.
module vga_sprite_renderer
   import vga_pkg::*;
(
   input  logic        pixel_clock,
   input  logic        rst_n,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic [31:0] x_in,
   input  logic [31:0] y_in,
   input  logic [9:0]  sprite_x,
   input  logic [8:0]  sprite_y,
   input  logic        sprite_en,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic [3:0]  red,
   output logic [3:0]  green,
   output logic [3:0]  blue,
   output logic        frame_tick
);

`ifdef SPRITE_SCALE2X_EN
   localparam logic [10:0] FOOT_W = SPRITE_W << 1;
   localparam logic [10:0] FOOT_H = SPRITE_H << 1;
`else
   localparam logic [10:0] FOOT_W = SPRITE_W;
   localparam logic [10:0] FOOT_H = SPRITE_H;
`endif

   logic        hs_d, hs_q, vs_d, vs_q;
   logic        hs_fall, vs_fall;
   logic [9:0]  hc_eff;
   logic [9:0]  h_cnt_d, h_cnt_q, v_cnt_d, v_cnt_q;
   logic        tick_d, tick_q;
   logic [9:0]  sx_d, sx_q;
   logic [8:0]  sy_d, sy_q;
   logic        en_d, en_q;
   logic [10:0] x11, y11, sx11, sy11, dx, dy;
   logic        hit, gnd, active;
   logic [4:0]  col, rom_addr;
   logic [31:0] rom_data;
   stage1_t     s1_d, s1_q;
   logic        on;
   rgb12_t      rgb_d, rgb_q;
   logic        hs2_d, hs2_q, vs2_d, vs2_q;
   logic        unused_bits;

   assign unused_bits = ^{x_in[31:10], y_in[31:9], dx, dy};

   // Counters are rebuilt from sync edges; both saturate at 1023 so nothing is active before the first vsync.
   always_comb begin
      hs_d    = hsync_in;
      vs_d    = vsync_in;
      hs_fall = hs_q & ~hsync_in;
      vs_fall = vs_q & ~vsync_in;
      hc_eff  = hs_fall ? 10'd0 : h_cnt_q;
      h_cnt_d = (hc_eff == CNT_MAX) ? CNT_MAX : hc_eff + 10'd1;
      v_cnt_d = v_cnt_q;
      if (vs_fall)                           v_cnt_d = 10'd0;
      else if (hs_fall && v_cnt_q != CNT_MAX) v_cnt_d = v_cnt_q + 10'd1;
      tick_d  = (v_cnt_d == V_ACT_END) && (v_cnt_q != V_ACT_END);
      sx_d    = tick_d ? sprite_x  : sx_q;
      sy_d    = tick_d ? sprite_y  : sy_q;
      en_d    = tick_d ? sprite_en : en_q;
      active  = (hc_eff >= H_ACT_START) && (hc_eff < H_ACT_END) &&
                (v_cnt_q >= V_ACT_START) && (v_cnt_q < V_ACT_END);
   end

   // Stage 0: 11-bit compares so a sprite near the right/bottom edge clips instead of wrapping.
   always_comb begin
      x11  = {1'b0, x_in[9:0]};
      y11  = {2'b00, y_in[8:0]};
      sx11 = {1'b0, sx_q};
      sy11 = {2'b00, sy_q};
      dx   = x11 - sx11;
      dy   = y11 - sy11;
      hit  = en_q && (x11 >= sx11) && (x11 < sx11 + FOOT_W) &&
                     (y11 >= sy11) && (y11 < sy11 + FOOT_H);
`ifdef SPRITE_SCALE2X_EN
      col      = dx[5:1];
      rom_addr = dy[5:1];
`else
      col      = dx[4:0];
      rom_addr = dy[4:0];
`endif
      gnd  = (y11 >= GROUND_Y) && (y11 < GROUND_Y + GROUND_H);
      s1_d = '{hit: hit, col: col, gnd: gnd, active: active, hs: hsync_in, vs: vsync_in};
   end

   trex_sprite_rom u_rom (
      .clk   (pixel_clock),
      .rst_n (rst_n),
      .addr  (rom_addr),
      .data  (rom_data)
   );

   // Stage 2: sprite beats ground beats background; blanking forces black.
   always_comb begin
      on = s1_q.hit & rom_data[5'd31 - s1_q.col];
      if (!s1_q.active)  rgb_d = 12'h000;
      else if (on)       rgb_d = FG_COLOR;
      else if (s1_q.gnd) rgb_d = GND_COLOR;
      else               rgb_d = BG_COLOR;
      hs2_d = s1_q.hs;
      vs2_d = s1_q.vs;
   end

   always_ff @(posedge pixel_clock or negedge rst_n) begin
      if (!rst_n) begin
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
         h_cnt_q <= CNT_MAX;
         v_cnt_q <= CNT_MAX;
         tick_q  <= 1'b0;
         sx_q    <= 10'd0;
         sy_q    <= 9'd0;
         en_q    <= 1'b0;
         s1_q    <= S1_RESET;
         rgb_q   <= 12'h000;
         hs2_q   <= 1'b1;
         vs2_q   <= 1'b1;
      end else begin
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         tick_q  <= tick_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         en_q    <= en_d;
         s1_q    <= s1_d;
         rgb_q   <= rgb_d;
         hs2_q   <= hs2_d;
         vs2_q   <= vs2_d;
      end
   end

   assign hsync_out  = hs2_q;
   assign vsync_out  = vs2_q;
   assign red        = rgb_q[11:8];
   assign green      = rgb_q[7:4];
   assign blue       = rgb_q[3:0];
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_vga_sprite_renderer.sv
// Directed bench for vga_sprite_renderer: abbreviated frames (2-cycle lines) with full 800-cycle lines where pixels are checked.
module tb_vga_sprite_renderer;

   logic        pixel_clock = 1'b0;
   logic        rst_n;
   logic        hsync_in, vsync_in;
   logic [31:0] x_in, y_in;
   logic [9:0]  sprite_x;
   logic [8:0]  sprite_y;
   logic        sprite_en;
   logic        hsync_out, vsync_out;
   logic [3:0]  red, green, blue;
   logic        frame_tick;

   int checks = 0;
   int passed = 0;

   logic [11:0] line_rgb [0:799];
   logic        line_hs  [0:799];
   logic        line_vs  [0:799];
   int cur_ln = 0, cur_hc = 0;
   int tick_cnt = 0, tick_ln = -1, tick_hc = -1;

   always #20 pixel_clock = ~pixel_clock;

   vga_sprite_renderer dut (
      .pixel_clock (pixel_clock),
      .rst_n       (rst_n),
      .hsync_in    (hsync_in),
      .vsync_in    (vsync_in),
      .x_in        (x_in),
      .y_in        (y_in),
      .sprite_x    (sprite_x),
      .sprite_y    (sprite_y),
      .sprite_en   (sprite_en),
      .hsync_out   (hsync_out),
      .vsync_out   (vsync_out),
      .red         (red),
      .green       (green),
      .blue        (blue),
      .frame_tick  (frame_tick)
   );

   // ---------------- driver tasks ----------------
   // Outputs sampled at this negedge belong to the inputs driven two negedges ago (hc-2).
   task automatic drive_cycle(input logic hs, input int ln, input int hc);
      @(negedge pixel_clock);
      if (frame_tick === 1'b1) begin
         tick_cnt++;
         tick_ln = cur_ln;
         tick_hc = cur_hc;
      end
      if (hc >= 2) begin
         line_rgb[hc-2] = {red, green, blue};
         line_hs[hc-2]  = hsync_out;
         line_vs[hc-2]  = vsync_out;
      end
      hsync_in = hs;
      vsync_in = (ln >= 2) ? 1'b1 : 1'b0;
      x_in     = (hc >= 144) ? 32'(hc - 144) : 32'd0;
      y_in     = (ln >= 31) ? 32'(ln - 31) : 32'd0;
      cur_ln   = ln;
      cur_hc   = hc;
   endtask

   task automatic fast_lines(input int a, input int b);
      for (int ln = a; ln <= b; ln++) begin
         drive_cycle(1'b0, ln, 0);
         drive_cycle(1'b1, ln, 1);
      end
   endtask

   task automatic full_line(input int ln);
      for (int hc = 0; hc < 800; hc++) drive_cycle(hc >= 96, ln, hc);
   endtask

   task automatic latch_sprite(input int sx, input int sy, input logic en);
      sprite_x  = 10'(sx);
      sprite_y  = 9'(sy);
      sprite_en = en;
      fast_lines(0, 520);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int t0;
      rst_n = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; x_in = 0; y_in = 0;
      sprite_x = 10'd0; sprite_y = 9'd0; sprite_en = 1'b1;
      repeat (3) @(negedge pixel_clock);
      checks++; if ({red, green, blue} !== 12'h000) $display("FAIL reset_rgb: got %h expected 000", {red, green, blue}); else passed++;
      checks++; if (hsync_out !== 1'b1) $display("FAIL reset_hsync: got %b expected 1", hsync_out); else passed++;
      checks++; if (vsync_out !== 1'b1) $display("FAIL reset_vsync: got %b expected 1", vsync_out); else passed++;
      checks++; if (frame_tick !== 1'b0) $display("FAIL reset_tick: got %b expected 0", frame_tick); else passed++;
      rst_n = 1'b1;
      t0 = tick_cnt;
      full_line(100);
      checks++; if (line_rgb[144] !== 12'h000) $display("FAIL pre_vsync_x0: got %h expected 000", line_rgb[144]); else passed++;
      checks++; if (line_rgb[444] !== 12'h000) $display("FAIL pre_vsync_x300: got %h expected 000", line_rgb[444]); else passed++;
      fast_lines(101, 520);
      checks++; if (tick_cnt - t0 !== 0) $display("FAIL pre_vsync_ticks: got %0d expected 0", tick_cnt - t0); else passed++;
   endtask

   task automatic test_first_frame();
      int hcs [5] = '{10, 143, 144, 783, 784};
      logic [11:0] ex [5] = '{12'h000, 12'h000, 12'hFFF, 12'hFFF, 12'h000};
      int t0 = tick_cnt;
      full_line(0);
      checks++; if (line_vs[300] !== 1'b0) $display("FAIL vsync_out_line0: got %b expected 0", line_vs[300]); else passed++;
      checks++; if (line_rgb[300] !== 12'h000) $display("FAIL vblank_line0: got %h expected 000", line_rgb[300]); else passed++;
      fast_lines(1, 29);
      full_line(30);
      checks++; if (line_rgb[400] !== 12'h000) $display("FAIL vblank_line30: got %h expected 000", line_rgb[400]); else passed++;
      full_line(31);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (line_rgb[hcs[i]] !== ex[i]) $display("FAIL first_line hc=%0d: got %h expected %h", hcs[i], line_rgb[hcs[i]], ex[i]);
         else passed++;
      end
      checks++; if (line_hs[95] !== 1'b0) $display("FAIL hsync_align hc95: got %b expected 0", line_hs[95]); else passed++;
      checks++; if (line_hs[96] !== 1'b1) $display("FAIL hsync_align hc96: got %b expected 1", line_hs[96]); else passed++;
      checks++; if (line_vs[300] !== 1'b1) $display("FAIL vsync_out_line31: got %b expected 1", line_vs[300]); else passed++;
      fast_lines(32, 520);
      checks++; if (tick_cnt - t0 !== 1) $display("FAIL first_frame_ticks: got %0d expected 1", tick_cnt - t0); else passed++;
      checks++; if (tick_ln !== 511 || tick_hc !== 0) $display("FAIL tick_position: got line %0d hc %0d expected line 511 hc 0", tick_ln, tick_hc); else passed++;
   endtask

`ifndef SPRITE_SCALE2X_EN
   task automatic test_sprite();
      int xs0 [5] = '{100, 131, 101, 132, 99};
      logic [11:0] ex0 [5] = '{12'h555, 12'h555, 12'hFFF, 12'hFFF, 12'hFFF};
      int xs1 [3] = '{118, 125, 117};
      logic [11:0] ex1 [3] = '{12'h555, 12'h555, 12'hFFF};
      latch_sprite(100, 200, 1'b1);
      fast_lines(0, 229);
      full_line(230);
      checks++; if (line_rgb[244] !== 12'hFFF) $display("FAIL above_sprite y=199: got %h expected FFF", line_rgb[244]); else passed++;
      full_line(231);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (line_rgb[xs0[i] + 144] !== ex0[i]) $display("FAIL sprite_row0 x=%0d: got %h expected %h", xs0[i], line_rgb[xs0[i] + 144], ex0[i]);
         else passed++;
      end
      full_line(232);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (line_rgb[xs1[i] + 144] !== ex1[i]) $display("FAIL sprite_row1 x=%0d: got %h expected %h", xs1[i], line_rgb[xs1[i] + 144], ex1[i]);
         else passed++;
      end
      fast_lines(233, 520);
   endtask

   task automatic test_ground();
      latch_sprite(100, 380, 1'b1);
      fast_lines(0, 430);
      full_line(431);
      checks++; if (line_rgb[444] !== 12'h333) $display("FAIL ground y=400 x=300: got %h expected 333", line_rgb[444]); else passed++;
      checks++; if (line_rgb[250] !== 12'h555) $display("FAIL sprite_over_ground y=400 x=106: got %h expected 555", line_rgb[250]); else passed++;
      checks++; if (line_rgb[244] !== 12'h333) $display("FAIL clear_bit_ground y=400 x=100: got %h expected 333", line_rgb[244]); else passed++;
      full_line(432);
      checks++; if (line_rgb[444] !== 12'h333) $display("FAIL ground y=401 x=300: got %h expected 333", line_rgb[444]); else passed++;
      checks++; if (line_rgb[251] !== 12'h555) $display("FAIL sprite_over_ground y=401 x=107: got %h expected 555", line_rgb[251]); else passed++;
      full_line(433);
      checks++; if (line_rgb[444] !== 12'hFFF) $display("FAIL below_ground y=402 x=300: got %h expected FFF", line_rgb[444]); else passed++;
      fast_lines(434, 520);
   endtask

   task automatic test_mid_frame_move();
      int t0;
      latch_sprite(100, 300, 1'b1);
      t0 = tick_cnt;
      fast_lines(0, 280);
      sprite_x = 10'd400;
      fast_lines(281, 330);
      full_line(331);
      checks++; if (line_rgb[244] !== 12'h555) $display("FAIL old_pos_kept x=100: got %h expected 555", line_rgb[244]); else passed++;
      checks++; if (line_rgb[544] !== 12'hFFF) $display("FAIL new_pos_early x=400: got %h expected FFF", line_rgb[544]); else passed++;
      fast_lines(332, 520);
      checks++; if (tick_cnt - t0 !== 1) $display("FAIL ticks_frame_a: got %0d expected 1", tick_cnt - t0); else passed++;
      checks++; if (tick_ln !== 511 || tick_hc !== 0) $display("FAIL tick_position_a: got line %0d hc %0d expected line 511 hc 0", tick_ln, tick_hc); else passed++;
      t0 = tick_cnt;
      fast_lines(0, 330);
      full_line(331);
      checks++; if (line_rgb[544] !== 12'h555) $display("FAIL new_pos x=400: got %h expected 555", line_rgb[544]); else passed++;
      checks++; if (line_rgb[575] !== 12'h555) $display("FAIL new_pos x=431: got %h expected 555", line_rgb[575]); else passed++;
      checks++; if (line_rgb[244] !== 12'hFFF) $display("FAIL old_pos_gone x=100: got %h expected FFF", line_rgb[244]); else passed++;
      fast_lines(332, 520);
      checks++; if (tick_cnt - t0 !== 1) $display("FAIL ticks_frame_b: got %0d expected 1", tick_cnt - t0); else passed++;
   endtask

   task automatic test_right_edge();
      int hcs0 [3] = '{764, 155, 784};
      logic [11:0] ex0 [3] = '{12'h555, 12'hFFF, 12'h000};
      int hcs1 [4] = '{782, 783, 144, 148};
      logic [11:0] ex1 [4] = '{12'h555, 12'h555, 12'hFFF, 12'hFFF};
      latch_sprite(620, 200, 1'b1);
      fast_lines(0, 230);
      full_line(231);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (line_rgb[hcs0[i]] !== ex0[i]) $display("FAIL edge_row0 hc=%0d: got %h expected %h", hcs0[i], line_rgb[hcs0[i]], ex0[i]);
         else passed++;
      end
      full_line(232);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (line_rgb[hcs1[i]] !== ex1[i]) $display("FAIL edge_row1 hc=%0d: got %h expected %h", hcs1[i], line_rgb[hcs1[i]], ex1[i]);
         else passed++;
      end
      fast_lines(233, 520);
   endtask

   task automatic test_sprite_disabled();
      latch_sprite(100, 200, 1'b0);
      fast_lines(0, 230);
      full_line(231);
      checks++; if (line_rgb[244] !== 12'hFFF) $display("FAIL disabled x=100: got %h expected FFF", line_rgb[244]); else passed++;
      checks++; if (line_rgb[275] !== 12'hFFF) $display("FAIL disabled x=131: got %h expected FFF", line_rgb[275]); else passed++;
      fast_lines(232, 520);
   endtask
`else
   task automatic test_scale2x();
      int xs [6] = '{100, 101, 102, 162, 163, 164};
      logic [11:0] ex [6] = '{12'h555, 12'h555, 12'hFFF, 12'h555, 12'h555, 12'hFFF};
      latch_sprite(100, 200, 1'b1);
      fast_lines(0, 230);
      full_line(231);
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (line_rgb[xs[i] + 144] !== ex[i]) $display("FAIL scale2x y=200 x=%0d: got %h expected %h", xs[i], line_rgb[xs[i] + 144], ex[i]);
         else passed++;
      end
      full_line(232);
      checks++; if (line_rgb[244] !== 12'h555) $display("FAIL scale2x y=201 x=100: got %h expected 555", line_rgb[244]); else passed++;
      checks++; if (line_rgb[245] !== 12'h555) $display("FAIL scale2x y=201 x=101: got %h expected 555", line_rgb[245]); else passed++;
      fast_lines(233, 520);
   endtask
`endif

   task automatic test_reset_mid_frame();
      int t0;
      fast_lines(0, 230);
      for (int hc = 0; hc < 400; hc++) drive_cycle(hc >= 96, 231, hc);
      #2;
      checks++; if ({red, green, blue} !== 12'hFFF) $display("FAIL pre_reset_rgb: got %h expected FFF", {red, green, blue}); else passed++;
      rst_n = 1'b0;
      #1;
      checks++; if ({red, green, blue} !== 12'h000) $display("FAIL mid_reset_rgb: got %h expected 000", {red, green, blue}); else passed++;
      checks++; if (hsync_out !== 1'b1 || vsync_out !== 1'b1) $display("FAIL mid_reset_syncs: got %b%b expected 11", hsync_out, vsync_out); else passed++;
      checks++; if (frame_tick !== 1'b0) $display("FAIL mid_reset_tick: got %b expected 0", frame_tick); else passed++;
      #5;
      rst_n = 1'b1;
      t0 = tick_cnt;
      full_line(232);
      checks++; if (line_rgb[444] !== 12'h000) $display("FAIL post_reset_black x=300: got %h expected 000", line_rgb[444]); else passed++;
      fast_lines(233, 520);
      checks++; if (tick_cnt - t0 !== 0) $display("FAIL post_reset_ticks: got %0d expected 0", tick_cnt - t0); else passed++;
      fast_lines(0, 30);
      full_line(31);
      checks++; if (line_rgb[444] !== 12'hFFF) $display("FAIL recovered_bg x=300: got %h expected FFF", line_rgb[444]); else passed++;
      fast_lines(32, 520);
   endtask

   initial begin
      test_reset();
      test_first_frame();
`ifndef SPRITE_SCALE2X_EN
      test_sprite();
      test_ground();
      test_mid_frame_move();
      test_right_edge();
      test_sprite_disabled();
`else
      test_scale2x();
`endif
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
